// File: rtl/ising_pkg.sv
// Shared types and helpers for the checkerboard Ising sweep controller.
// Lattice bits are packed row-major: bit i*L+j holds spin[i][j].
package ising_pkg;

    localparam int L_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WHITE,
        S_GREY,
        S_SNAP,
        S_STREAM,
        S_DONE
    } state_t;

    function automatic int mag_width(input int l);
        return $clog2(l * l) + 2;
    endfunction

    function automatic int lat_idx(input int i, input int j, input int l);
        return i * l + j;
    endfunction

endpackage

// File: rtl/ising_row_popcount.sv
// Combinational popcount of one lattice row.
module ising_row_popcount #(
    parameter int L  = 8,
    parameter int CW = $clog2(L + 1)
) (
    input  logic [L-1:0]  bits,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int j = 0; j < L; j++)
            count = count + CW'(bits[j]);
    end

endmodule

// File: rtl/ising_sweep_ctrl.sv
// Sweep sequencer, snapshot streamer and magnetization readout.
// Magnetization logic is built only when ISING_MAG_EN is defined.
module ising_sweep_ctrl
    import ising_pkg::*;
#(
    parameter int L       = L_DEF,
    parameter int SWEEP_W = 16,
    parameter int MAG_W   = mag_width(L)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SWEEP_W-1:0]      num_sweeps,
    input  logic [L*L-1:0]          lattice_in,
    output logic                    enable_white,
    output logic                    enable_grey,
    output logic                    busy,
    output logic [L-1:0]            row_data,
    output logic [$clog2(L)-1:0]    row_idx,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic signed [MAG_W-1:0] mag,
    output logic                    mag_valid,
    output logic                    done
);

    localparam int IW = $clog2(L);

    state_t             state;
    state_t             state_nx;
    logic [SWEEP_W-1:0] cnt;
    logic [L*L-1:0]     snap;
    logic               accept;
    logic               last;

    assign accept   = row_valid & row_ready;
    assign last     = accept && (row_idx == IW'(L - 1));
    assign row_data = snap[row_idx * L +: L];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:
                if (start)
                    state_nx = (num_sweeps != '0) ? S_WHITE : S_SNAP;
            S_WHITE:  state_nx = S_GREY;
            S_GREY:
                state_nx = (cnt == SWEEP_W'(1)) ? S_SNAP : S_WHITE;
            S_SNAP:   state_nx = S_STREAM;
            S_STREAM: if (last) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_white <= 1'b0;
            enable_grey  <= 1'b0;
            busy         <= 1'b0;
            row_valid    <= 1'b0;
            done         <= 1'b0;
            cnt          <= '0;
            snap         <= '0;
            row_idx      <= '0;
        end else begin
            enable_white <= (state_nx == S_WHITE);
            enable_grey  <= (state_nx == S_GREY);
            row_valid    <= (state_nx == S_STREAM);
            done         <= (state_nx == S_DONE);
            busy         <= (state_nx != S_IDLE);
            if (state == S_IDLE && start)
                cnt <= num_sweeps;
            if (state == S_GREY)
                cnt <= cnt - SWEEP_W'(1);
            if (state == S_SNAP) begin
                snap    <= lattice_in;
                row_idx <= '0;
            end else if (accept) begin
                row_idx <= row_idx + 1'b1;
            end
        end
    end

`ifdef ISING_MAG_EN
    localparam int AW = $clog2(L * L) + 1;
    localparam int CW = $clog2(L + 1);

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nx;
    logic [CW-1:0] pc;

    ising_row_popcount #(.L(L), .CW(CW)) u_pc (
        .bits  (row_data),
        .count (pc)
    );

    assign acc_nx = acc + AW'(pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            mag       <= '0;
            mag_valid <= 1'b0;
        end else begin
            if (state == S_IDLE && start)
                mag_valid <= 1'b0;
            if (state == S_SNAP)
                acc <= '0;
            else if (accept)
                acc <= acc_nx;
            if (last) begin
                mag       <= MAG_W'({acc_nx, 1'b0}) - MAG_W'(L * L);
                mag_valid <= 1'b1;
            end
        end
    end
`else
    assign mag       = '0;
    assign mag_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ising_sweep_ctrl.sv
// Self-checking bench for ising_sweep_ctrl with a toy spin-array stand-in.
// Expected lattices and magnetization come from a sweep-level model.
module tb_ising_sweep_ctrl;

    localparam int L = 8;
`ifdef ISING_MAG_EN
    localparam bit MAG_ON = 1'b1;
`else
    localparam bit MAG_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              row_ready = 1'b1;
    logic [15:0]       num_sweeps = '0;
    logic [63:0]       lattice_in;
    logic              enable_white;
    logic              enable_grey;
    logic              busy;
    logic              row_valid;
    logic              mag_valid;
    logic              done;
    logic [7:0]        row_data;
    logic [2:0]        row_idx;
    logic signed [7:0] mag;

    int n_assert = 0;
    int n_fail = 0;

    logic [63:0] arr = '0;
    logic [63:0] load_val = '0;
    logic [63:0] wmask = '0;
    logic [63:0] gadd = '0;
    logic        load = 1'b0;

    always #5 clk = ~clk;

    // Stand-in spin array: white phase XORs a mask, grey phase adds.
    always @(posedge clk) begin
        if (load)
            arr <= load_val;
        else if (enable_white)
            arr <= arr ^ wmask;
        else if (enable_grey)
            arr <= arr + gadd;
    end
    assign lattice_in = arr;

    ising_sweep_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_sweeps   (num_sweeps),
        .lattice_in   (lattice_in),
        .enable_white (enable_white),
        .enable_grey  (enable_grey),
        .busy         (busy),
        .row_data     (row_data),
        .row_idx      (row_idx),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .mag          (mag),
        .mag_valid    (mag_valid),
        .done         (done)
    );

    function automatic logic [63:0] model(input logic [63:0] x,
                                          input int n);
        for (int s = 0; s < n; s++) begin
            x = x ^ wmask;
            x = x + gadd;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic load_lat(input logic [63:0] v);
        @(negedge clk);
        load_val = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input string tag, input int n,
                       input logic [63:0] lat0, input int stall_row,
                       input int stall_len, input bit poke);
        logic [63:0] w_obs = '0;
        logic [63:0] g_obs = '0;
        logic [63:0] w_exp = '0;
        logic [63:0] g_exp = '0;
        logic [63:0] rows = '0;
        logic [63:0] exp_lat;
        logic [7:0]  exp_mag;
        logic [7:0]  mag_d = '0;
        logic        mv_d = 1'b0;
        logic [7:0]  hd = '0;
        logic [2:0]  hi = '0;
        int          first_v = -1;
        int          done_c = -1;
        int          stalled = 0;
        int          nxt = 0;
        bit          both = 0;
        bit          unstable = 0;
        bit          order_err = 0;

        load_lat(lat0);
        exp_lat = model(lat0, n);
        exp_mag = 8'(2 * $countones(exp_lat) - L * L);
        for (int s = 0; s < n; s++) begin
            w_exp[2*s+1] = 1'b1;
            g_exp[2*s+2] = 1'b1;
        end

        @(negedge clk);
        start = 1'b1;
        num_sweeps = 16'(n);
        row_ready = 1'b1;
        for (int k = 1; k < 300 && done_c < 0; k++) begin
            @(negedge clk);
            start = poke && (k == 3);
            if (poke && k == 3)
                num_sweeps = 16'(n + 4);
            if (k < 64) begin
                w_obs[k] = enable_white;
                g_obs[k] = enable_grey;
            end
            if (enable_white && enable_grey)
                both = 1;
            if (k == 1)
                chk({tag, "_mv_clr"}, 64'(mag_valid), 64'd0);
            if (row_valid && first_v < 0)
                first_v = k;
            if (done) begin
                done_c = k;
                mag_d = mag;
                mv_d = mag_valid;
            end
            row_ready = 1'b1;
            if (row_valid) begin
                if (row_idx == 3'(stall_row) && stalled < stall_len) begin
                    if (stalled == 0) begin
                        hd = row_data;
                        hi = row_idx;
                    end else if (row_data !== hd || row_idx !== hi) begin
                        unstable = 1;
                    end
                    stalled++;
                    row_ready = 1'b0;
                end else begin
                    if (int'(row_idx) != nxt)
                        order_err = 1;
                    rows[int'(row_idx)*8 +: 8] = row_data;
                    nxt++;
                end
            end
        end
        row_ready = 1'b1;

        chk({tag, "_done_seen"}, 64'(done_c >= 0), 64'd1);
        chk({tag, "_white_seq"}, w_obs, w_exp);
        chk({tag, "_grey_seq"}, g_obs, g_exp);
        chk({tag, "_en_overlap"}, 64'(both), 64'd0);
        chk({tag, "_first_valid"}, 64'(first_v), 64'(2 * n + 2));
        chk({tag, "_done_cyc"}, 64'(done_c),
            64'(2 * n + L + 2 + stall_len));
        chk({tag, "_rows"}, rows, exp_lat);
        chk({tag, "_row_order"}, 64'(order_err), 64'd0);
        chk({tag, "_stable"}, 64'(unstable), 64'd0);
        chk({tag, "_mag"}, {56'd0, mag_d}, MAG_ON ? {56'd0, exp_mag} : 64'd0);
        chk({tag, "_mag_valid"}, 64'(mv_d), 64'(MAG_ON));

        @(negedge clk);
        chk({tag, "_post"}, {61'd0, done, busy, row_valid}, 64'd0);
        chk({tag, "_hold"}, {55'd0, mag_valid, mag},
            MAG_ON ? {55'd0, 1'b1, exp_mag} : 64'd0);
    endtask

    initial begin
        #12;
        chk("rst_ctl", {58'd0, enable_white, enable_grey, busy,
                        row_valid, done, mag_valid}, 64'd0);
        chk("rst_row", {53'd0, row_data, row_idx}, 64'd0);
        chk("rst_mag", {56'd0, mag}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        wmask = {$urandom, $urandom};
        gadd  = {$urandom, $urandom};
        run("seq3", 3, {$urandom, $urandom}, -1, 0, 0);

        run("ones", 0, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 0);
        run("zeros", 0, 64'h0, -1, 0, 0);
        run("checker", 0, 64'hAA55_AA55_AA55_AA55, -1, 0, 0);
        run("bp", 2, {$urandom, $urandom}, 2, 5, 0);
        run("n0", 0, 64'h0000_0000_0000_FFFF, -1, 0, 0);
        run("poke", 3, {$urandom, $urandom}, -1, 0, 1);

        for (int r = 0; r < 6; r++) begin
            wmask = {$urandom, $urandom};
            gadd  = {$urandom, $urandom};
            run($sformatf("rnd%0d", r), int'($urandom_range(1, 6)),
                {$urandom, $urandom}, int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), 0);
        end

        load_lat({$urandom, $urandom});
        @(negedge clk);
        start = 1'b1;
        num_sweeps = 16'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid_grey", 64'(enable_grey), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async", {59'd0, enable_white, enable_grey, busy,
                          row_valid, done}, 64'd0);
        chk("rst_async_mv", 64'(mag_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_idle", {61'd0, busy, enable_white, enable_grey}, 64'd0);
        run("post_rst", 1, {$urandom, $urandom}, -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
